// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converters: FSM states, digit
// constants and a constant-evaluable clog2 used to size the bit counter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = BCD_DIGIT_W'(5);
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = BCD_DIGIT_W'(3);

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digitIn,
  output logic [BCD_DIGIT_W-1:0] digitOut
);

  // Inputs are 0..9 in normal use, so the 4-bit sum never wraps (max 12).
  assign digitOut = (digitIn >= ADJ_THRESHOLD) ? digitIn + ADJ_ADD : digitIn;

endmodule

// File: rtl/seq_binary_to_bcd.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake and an overflow flag for narrow outputs.
module seq_binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic [BIN_WIDTH-1:0]          BinaryIn,
  output logic                          Busy,
  output logic                          Done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BcdOut,
  output logic                          Overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  stateT                stateReg;
  logic [BIN_WIDTH-1:0] binReg;
  logic [BCD_W-1:0]     scratchReg;
  logic                 ovfAccReg;
  logic [CNT_W-1:0]     cntReg;

  logic [BCD_W-1:0]     adjusted;
  logic [BCD_W-1:0]     scratchNext;
  logic [BIN_WIDTH-1:0] binNext;
  logic                 shiftOut;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : gAdjust
    bcd_digit_adjust uAdjust (
      .digitIn  (scratchReg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digitOut (adjusted[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Treat {scratch, binary} as one register; the bit leaving the top digit
  // is the overflow candidate. Written as a concatenation so BIN_WIDTH=1 works.
  assign {shiftOut, scratchNext, binNext} = {adjusted, binReg, 1'b0};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg   <= IDLE;
      binReg     <= '0;
      scratchReg <= '0;
      ovfAccReg  <= 1'b0;
      cntReg     <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      BcdOut     <= '0;
      Overflow   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (Start) begin
            binReg     <= BinaryIn;
            scratchReg <= '0;
            ovfAccReg  <= 1'b0;
            cntReg     <= CNT_LOAD;
            Busy       <= 1'b1;
            stateReg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratchReg <= scratchNext;
          binReg     <= binNext;
          ovfAccReg  <= ovfAccReg | shiftOut;
          cntReg     <= cntReg - CNT_LAST;
          if (cntReg == CNT_LAST) begin
            Busy     <= 1'b0;
            stateReg <= DONE;
          end
        end
        DONE: begin
          BcdOut   <= scratchReg;
          Overflow <= ovfAccReg;
          Done     <= 1'b1;
          stateReg <= IDLE;
        end
        default: begin
          Busy     <= 1'b0;
          stateReg <= IDLE;
        end
      endcase
    end
  end

endmodule
